// File: rtl/io_fifo_port.sv
// Memory-mapped IO responder with a CPU-written TX FIFO, a CPU-read RX FIFO
// and a status/control register, all behind a 4-word IO window at BASE.
module io_fifo_port #(
  parameter int          DEPTH = 8,
  parameter int          DW    = 16,
  parameter logic [15:0] BASE  = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iom_in,
  input  logic          wen_in,
  input  logic [15:0]   addr_in,
  input  logic [DW-1:0] wdata_in,
  output logic [DW-1:0] rdata_out,
  output logic [DW-1:0] tx_data_out,
  output logic          tx_valid_out,
  input  logic          tx_ready_in,
  input  logic [DW-1:0] rx_data_in,
  input  logic          rx_valid_in,
  output logic          rx_ready_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];

  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf, rx_unf;

  logic       hit, io_wr, io_rd;
  logic [1:0] off;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push_req, tx_push, tx_pop, tx_flush;
  logic       rx_pop_req, rx_pop, rx_push, rx_flush;
  logic       sts_clr;
  logic       tx_ovf_next, rx_unf_next;
  logic [DW-1:0] status, rx_head;

  assign hit   = iom_in & (addr_in[15:2] == BASE[15:2]);
  assign off   = addr_in[1:0];
  assign io_wr = hit & ~wen_in;
  assign io_rd = hit & wen_in;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  // Fullness/emptiness before the edge decides drop/underflow, regardless of
  // whatever the external side does in the same cycle.
  assign tx_push_req = io_wr & (off == 2'd0);
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = ~tx_empty & tx_ready_in;
  assign tx_flush    = io_wr & (off == 2'd3) & wdata_in[0];

  assign rx_pop_req = io_rd & (off == 2'd1);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_push    = rx_valid_in & ~rx_full;
  assign rx_flush   = io_wr & (off == 2'd3) & wdata_in[1];

  assign sts_clr = io_wr & (off == 2'd2);

  assign tx_ovf_next = (tx_ovf & ~(sts_clr & wdata_in[4])) | (tx_push_req & tx_full);
  assign rx_unf_next = (rx_unf & ~(sts_clr & wdata_in[5])) | (rx_pop_req & rx_empty);

  // Storage is uninitialised after reset, so heads are masked while empty.
  assign tx_valid_out = ~tx_empty;
  assign tx_data_out  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
  assign rx_ready_out = ~rx_full;
  assign rx_head      = rx_empty ? '0 : rx_mem[rx_rd_ptr];

  always_comb begin
    status            = '0;
    status[0]         = rx_empty;
    status[1]         = rx_full;
    status[2]         = tx_empty;
    status[3]         = tx_full;
    status[4]         = tx_ovf;
    status[5]         = rx_unf;
    status[8 +: CW]   = rx_count;
  end

  always_comb begin
    rdata_out = '0;
    if (io_rd) begin
      case (off)
        2'd1:    rdata_out = rx_head;
        2'd2:    rdata_out = status;
        default: rdata_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wdata_in;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
    end else begin
      tx_ovf <= tx_ovf_next;
      rx_unf <= rx_unf_next;

      if (tx_flush) begin
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
        tx_count  <= '0;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
        case ({tx_push, tx_pop})
          2'b10:   tx_count <= tx_count + CW'(1);
          2'b01:   tx_count <= tx_count - CW'(1);
          default: tx_count <= tx_count;
        endcase
      end

      if (rx_flush) begin
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        rx_count  <= '0;
      end else begin
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
        case ({rx_push, rx_pop})
          2'b10:   rx_count <= rx_count + CW'(1);
          2'b01:   rx_count <= rx_count - CW'(1);
          default: rx_count <= rx_count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_io_fifo_port.sv
// Directed plus randomized checks of io_fifo_port against a queue-based model.
module tb_io_fifo_port;
  localparam int          DEPTH = 8;
  localparam int          DW    = 16;
  localparam logic [15:0] BASE  = 16'h0040;

  logic          clk, rst_n;
  logic          iom, wen;
  logic [15:0]   addr;
  logic [DW-1:0] wdata, rdata, tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, rx_ready;

  io_fifo_port #(.DEPTH(DEPTH), .DW(DW), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .iom_in(iom), .wen_in(wen), .addr_in(addr),
    .wdata_in(wdata), .rdata_out(rdata), .tx_data_out(tx_data),
    .tx_valid_out(tx_valid), .tx_ready_in(tx_ready), .rx_data_in(rx_data),
    .rx_valid_in(rx_valid), .rx_ready_out(rx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic        m_ovf, m_unf;
  logic [15:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    return {8'(rx_q.size()), 2'b00, m_unf, m_ovf,
            tx_q.size() == DEPTH, tx_q.size() == 0,
            rx_q.size() == DEPTH, rx_q.size() == 0};
  endfunction

  function automatic logic m_hit();
    return iom && ((addr >> 2) == (BASE >> 2));
  endfunction

  function automatic logic [15:0] m_rdata();
    if (!(m_hit() && wen)) return 16'h0;
    if (addr[1:0] == 2'd1) return (rx_q.size() != 0) ? rx_q[0] : 16'h0;
    if (addr[1:0] == 2'd2) return m_status();
    return 16'h0;
  endfunction

  task automatic model_tick();
    logic wr, rd, tx_full_pre, rx_empty_pre, rx_full_pre, ovf_set, unf_set;
    logic [1:0] o;
    wr = m_hit() && !wen;
    rd = m_hit() && wen;
    o  = addr[1:0];
    tx_full_pre  = (tx_q.size() == DEPTH);
    rx_empty_pre = (rx_q.size() == 0);
    rx_full_pre  = (rx_q.size() == DEPTH);
    ovf_set = wr && o == 2'd0 && tx_full_pre;
    unf_set = rd && o == 2'd1 && rx_empty_pre;
    if (tx_q.size() != 0 && tx_ready) void'(tx_q.pop_front());
    if (wr && o == 2'd0 && !tx_full_pre) tx_q.push_back(wdata);
    if (rd && o == 2'd1 && !rx_empty_pre) void'(rx_q.pop_front());
    if (rx_valid && !rx_full_pre) rx_q.push_back(rx_data);
    if (wr && o == 2'd2 && wdata[4]) m_ovf = 1'b0;
    if (wr && o == 2'd2 && wdata[5]) m_unf = 1'b0;
    if (ovf_set) m_ovf = 1'b1;
    if (unf_set) m_unf = 1'b1;
    if (wr && o == 2'd3 && wdata[0]) tx_q.delete();
    if (wr && o == 2'd3 && wdata[1]) rx_q.delete();
  endtask

  // Inputs are driven just after a rising edge; outputs are checked late in the cycle.
  task automatic step();
    #3;
    last_rdata = rdata;
    chk("rdata", rdata, m_rdata());
    chk("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
    chk("rx_ready", rx_ready, rx_q.size() != DEPTH);
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iow(input logic [1:0] o, input logic [15:0] d);
    iom = 1'b1; wen = 1'b0; addr = BASE + 16'(o); wdata = d;
    step();
    iom = 1'b0;
  endtask

  task automatic ior(input logic [1:0] o);
    iom = 1'b1; wen = 1'b1; addr = BASE + 16'(o); wdata = 16'h0;
    step();
    iom = 1'b0;
  endtask

  task automatic idle();
    iom = 1'b0;
    step();
  endtask

  int r;
  logic [1:0] ro;

  initial begin
    rst_n = 1'b0; iom = 1'b0; wen = 1'b1; addr = 16'h0; wdata = 16'h0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0;
    m_ovf = 1'b0; m_unf = 1'b0; last_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_tx_data", tx_data, 16'h0);
    chk("rst_rdata", rdata, 16'h0);
    rst_n = 1'b1;

    // TX writes become visible on the next cycle
    iow(2'd0, 16'hA5A5);
    chk("tx_valid_after_wr", tx_valid, 1'b1);
    chk("tx_head_after_wr", tx_data, 16'hA5A5);
    iow(2'd0, 16'h1234);
    ior(2'd2);
    chk("status_rx_empty", last_rdata, 16'h0001);

    // Drain both words
    tx_ready = 1'b1;
    idle();
    chk("tx_second_head", tx_data, 16'h1234);
    idle();
    tx_ready = 1'b0;
    chk("tx_drained", tx_valid, 1'b0);
    ior(2'd2);
    chk("status_tx_empty", last_rdata, 16'h0005);

    // Overflow, W1C and flush
    for (int i = 0; i < 9; i++) iow(2'd0, 16'h0100 + 16'(i));
    ior(2'd2);
    chk("status_ovf", last_rdata, 16'h0019);
    iow(2'd2, 16'h0010);
    ior(2'd2);
    chk("status_ovf_clr", last_rdata, 16'h0009);
    iow(2'd3, 16'h0001);
    ior(2'd2);
    chk("status_tx_flush", last_rdata, 16'h0005);

    // RX fill, pop while source still valid, refill
    rx_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      rx_data = 16'(i);
      idle();
    end
    rx_data = 16'h0009;
    chk("rx_full_ready", rx_ready, 1'b0);
    ior(2'd2);
    chk("status_rx_full", last_rdata, 16'h0806);
    ior(2'd1);
    chk("rx_pop_data", last_rdata, 16'h0001);
    chk("rx_ready_after_pop", rx_ready, 1'b1);
    idle();
    rx_valid = 1'b0;
    ior(2'd2);
    chk("status_rx_refill", last_rdata, 16'h0806);

    // Underflow with a same-cycle push
    iow(2'd3, 16'h0002);
    rx_valid = 1'b1; rx_data = 16'hBEEF;
    ior(2'd1);
    rx_valid = 1'b0;
    chk("rx_unf_rdata", last_rdata, 16'h0000);
    ior(2'd2);
    chk("status_unf", last_rdata, 16'h0124);
    ior(2'd1);
    chk("rx_after_unf", last_rdata, 16'hBEEF);
    iow(2'd2, 16'h0020);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r  = $urandom_range(0, 99);
      ro = 2'($urandom_range(0, 3));
      iom = (r < 60);
      wen = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? BASE + 16'h0004 + 16'(ro) : BASE + 16'(ro);
      wdata = 16'($urandom);
      if (ro == 2'd3 && $urandom_range(0, 7) != 0) wdata[1:0] = 2'b00;
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 16'($urandom);
      step();
    end

    // Asynchronous reset with both FIFOs partly occupied
    iom = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    iow(2'd3, 16'h0003);
    iow(2'd0, 16'h1111);
    iow(2'd0, 16'h2222);
    rx_valid = 1'b1; rx_data = 16'h3333;
    idle();
    idle();
    rx_valid = 1'b0;
    chk("pre_reset_tx_valid", tx_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_valid", tx_valid, 1'b0);
    chk("async_rst_rx_ready", rx_ready, 1'b1);
    chk("async_rst_tx_data", tx_data, 16'h0);
    tx_q.delete(); rx_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ior(2'd2);
    chk("status_after_reset", last_rdata, 16'h0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
